// File: rtl/disp_scan_ctrl_if.sv
// Bus between a number source and disp_scan_ctrl: display data/update handshake in,
// anode/segment drive and frame pulse out.
interface disp_scan_ctrl_if #(
  parameter int NUM_DIG = 8
);
  logic                   i_en;
  logic [4*NUM_DIG-1:0]   i_data;
  logic [NUM_DIG-1:0]     i_dp;
  logic                   i_upd;
  logic                   o_upd_ack;
  logic [NUM_DIG-1:0]     o_an;
  logic [7:0]             o_seg;
  logic                   o_frame_done;

  modport master (
    output i_en, i_data, i_dp, i_upd,
    input  o_upd_ack, o_an, o_seg, o_frame_done
  );

  modport slave (
    input  i_en, i_data, i_dp, i_upd,
    output o_upd_ack, o_an, o_seg, o_frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with frame-synchronous data latch.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module disp_scan_ctrl #(
  parameter int NUM_DIG  = 8,
  parameter int SCAN_CYC = 100000,
  parameter int GAP_CYC  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  disp_scan_ctrl_if.slave    bus
);

  localparam int MAX_CYC = (SCAN_CYC > GAP_CYC) ? SCAN_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam int IDX_W   = $clog2(NUM_DIG);

  localparam logic [CNT_W-1:0]   SCAN_LAST = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIG - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [NUM_DIG-1:0] AN_OFF    = {NUM_DIG{1'b1}};
  localparam logic [NUM_DIG-1:0] AN_ONE    = NUM_DIG'(1);

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every higher digit is zero with no decimal point lit.
  function automatic logic lz_blank(input logic [4*NUM_DIG-1:0] d,
                                    input logic [NUM_DIG-1:0]   p,
                                    input logic [IDX_W-1:0]     idx);
    logic z;
    z = (idx != {IDX_W{1'b0}});
    for (int i = 0; i < NUM_DIG; i++) begin
      if ((i >= int'(idx)) && ((d[4*i +: 4] != 4'h0) || p[i])) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction
`endif

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_primed;
  logic [4*NUM_DIG-1:0] r_data_sh;
  logic [NUM_DIG-1:0]   r_dp_sh;
  logic [NUM_DIG-1:0]   r_an;
  logic [7:0]           r_seg;
  logic                 r_frame_done;
  logic                 r_upd_ack;

  logic [3:0]           w_nib;
  logic [7:0]           w_seg_hex;
  logic [7:0]           w_seg_show;
  logic [IDX_W-1:0]     w_idx_next;

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    w_nib      = r_data_sh[4*r_idx +: 4];
    w_seg_hex  = hex_to_seg(w_nib);
    w_idx_next = (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : (r_idx + IDX_ONE);
`ifdef LEADING_ZERO_BLANK_EN
    if (lz_blank(r_data_sh, r_dp_sh, r_idx)) begin
      w_seg_show = 8'hFF;
    end else begin
      w_seg_show = {~r_dp_sh[r_idx], w_seg_hex[6:0]};
    end
`else
    w_seg_show = {~r_dp_sh[r_idx], w_seg_hex[6:0]};
`endif
  end

  // Scan FSM with registered pin drive; the first gap after reset leads into digit 0 without advancing.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_GAP;
      r_cnt        <= {CNT_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_primed     <= 1'b0;
      r_data_sh    <= {(4*NUM_DIG){1'b0}};
      r_dp_sh      <= {NUM_DIG{1'b0}};
      r_an         <= AN_OFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
      r_upd_ack    <= 1'b0;
    end else if (!bus.i_en) begin
      r_an         <= AN_OFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
      r_upd_ack    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_upd_ack    <= 1'b0;
      case (r_state)
        ST_SHOW: begin
          r_an  <= ~(AN_ONE << r_idx);
          r_seg <= w_seg_show;
          if (r_cnt == SCAN_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_GAP: begin
          r_an  <= AN_OFF;
          r_seg <= 8'hFF;
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_SHOW;
            if (r_primed) begin
              r_idx <= w_idx_next;
              // Frame boundary: the only point where fresh display data may enter.
              if (r_idx == IDX_LAST) begin
                r_frame_done <= 1'b1;
                if (bus.i_upd) begin
                  r_upd_ack <= 1'b1;
                  r_data_sh <= bus.i_data;
                  r_dp_sh   <= bus.i_dp;
                end else begin
                  r_upd_ack <= 1'b0;
                end
              end else begin
                r_frame_done <= 1'b0;
              end
            end else begin
              r_primed <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_GAP;
          r_cnt   <= {CNT_W{1'b0}};
          r_an    <= AN_OFF;
          r_seg   <= 8'hFF;
        end
      endcase
    end
  end

  assign bus.o_an         = r_an;
  assign bus.o_seg        = r_seg;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_upd_ack    = r_upd_ack;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a cycle-position model checked every clock plus directed literal checks.
// Define LEADING_ZERO_BLANK_EN to also exercise leading-zero blanking.
module tb_disp_scan_ctrl;
  localparam int N     = 4;
  localparam int S     = 4;
  localparam int G     = 2;
  localparam int PER   = S + G;
  localparam int FRAME = N * PER;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;

  disp_scan_ctrl_if #(.NUM_DIG(N)) bus ();

  disp_scan_ctrl #(.NUM_DIG(N), .SCAN_CYC(S), .GAP_CYC(G)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: expected outputs derived from the number of enabled cycles since reset release.
  logic [7:0]       dec_tbl [16];
  int               k;
  logic             mvalid;
  logic [4*N-1:0]   sh_data;
  logic [N-1:0]     sh_dp;
  logic [N-1:0]     e_an;
  logic [7:0]       e_seg;
  logic             e_fd;
  logic             e_ack;
  int               mj, md, mw;
  logic             mshow, mfd;
  logic [3:0]       mnib;
  logic [7:0]       mtmp;

  initial begin
    dec_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    mvalid = 1'b0;
    cyc = 0;
    k = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      k = 0; sh_data = '0; sh_dp = '0;
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0; e_ack = 1'b0;
      mvalid = 1'b1;
    end else if (!bus.i_en) begin
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0; e_ack = 1'b0;
    end else begin
      if (k < G) begin
        mshow = 1'b0; mfd = 1'b0; md = 0;
      end else begin
        mj = (k - G) % FRAME;
        md = mj / PER;
        mw = mj % PER;
        mshow = (mw < S);
        mfd = (mw == PER - 1) && (md == N - 1);
      end
      if (mshow) begin
        mnib = 4'((sh_data >> (4 * md)) & 16'h000F);
        mtmp = dec_tbl[mnib];
        e_seg = {~sh_dp[md], mtmp[6:0]};
`ifdef LEADING_ZERO_BLANK_EN
        if (md != 0 && (sh_data >> (4 * md)) == 16'h0000 && (sh_dp >> md) == 4'h0) e_seg = 8'hFF;
`endif
        e_an = ~(4'b0001 << md);
      end else begin
        e_an = 4'hF; e_seg = 8'hFF;
      end
      e_fd = mfd;
      e_ack = mfd && bus.i_upd;
      if (e_ack) begin
        sh_data = bus.i_data;
        sh_dp = bus.i_dp;
      end
      k++;
    end
    #1;
    if (mvalid) begin
      chk("m_an", 32'(bus.o_an), 32'(e_an));
      chk("m_seg", 32'(bus.o_seg), 32'(e_seg));
      chk("m_frame_done", 32'(bus.o_frame_done), 32'(e_fd));
      chk("m_upd_ack", 32'(bus.o_upd_ack), 32'(e_ack));
    end
  end

  task automatic wait_fd(input string name, output int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_frame_done !== 1'b1 && n < 80);
    if (bus.o_frame_done !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic wait_an(input logic [3:0] want, input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_an !== want && n < 80);
    if (bus.o_an !== want) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_digit(input int d, input logic [7:0] exp, input string name);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    wait_an(want, name);
    chk(name, 32'(bus.o_seg), 32'(exp));
  endtask

  initial begin
    int t0, t1, n;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.i_en = 1'b1; bus.i_data = '0; bus.i_dp = '0; bus.i_upd = 1'b0;

    // 1: reset state, first digit latency, frame period
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.o_an), 32'h0000_000F);
    chk("rst_seg", 32'(bus.o_seg), 32'h0000_00FF);
    chk("rst_ack", 32'(bus.o_upd_ack), 32'd0);
    rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_an !== 4'hE && n < 3);
    chk("first_digit0", 32'(bus.o_an), 32'h0000_000E);
    wait_fd("fd_a", t0);
    wait_fd("fd_b", t1);
    chk("frame_period", 32'(t1 - t0), 32'd24);

    // 2: update handshake and new frame contents
    bus.i_data = 16'h12AF; bus.i_dp = 4'b0100; bus.i_upd = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_upd_ack !== 1'b1 && n < 80);
    chk("ack_seen", 32'(bus.o_upd_ack), 32'd1);
    chk("ack_on_fd", 32'(bus.o_frame_done), 32'd1);
    bus.i_upd = 1'b0;
    wait_digit(0, 8'h8E, "upd_d0");
    wait_digit(1, 8'h88, "upd_d1");
    wait_digit(2, 8'h24, "upd_d2");
    wait_digit(3, 8'hF9, "upd_d3");

    // 3: data changes without upd are not displayed
    bus.i_data = 16'h3456; bus.i_dp = 4'b1111;
    wait_digit(0, 8'h8E, "hold_d0");
    wait_digit(1, 8'h88, "hold_d1");
    wait_digit(2, 8'h24, "hold_d2");
    wait_digit(3, 8'hF9, "hold_d3");
    wait_fd("fd_c", t0);

    // 4: freeze for 10 cycles during digit 2
    wait_an(4'hB, "frz_wait");
    bus.i_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("frz_an", 32'(bus.o_an), 32'h0000_000F);
      chk("frz_fd", 32'(bus.o_frame_done), 32'd0);
    end
    bus.i_en = 1'b1;
    wait_fd("fd_d", t1);
    chk("frz_period", 32'(t1 - t0), 32'd34);

    // 5: reset mid digit 3 clears the shadow register
    wait_an(4'h7, "rst2_wait");
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_an", 32'(bus.o_an), 32'h0000_000F);
    chk("rst2_seg", 32'(bus.o_seg), 32'h0000_00FF);
    rst = 1'b1;
    wait_digit(0, 8'hC0, "rst2_d0");

`ifdef LEADING_ZERO_BLANK_EN
    // 6: leading-zero blanking and its cancellation by a decimal point
    bus.i_data = 16'h0050; bus.i_dp = 4'b0000; bus.i_upd = 1'b1;
    wait_an(4'hF, "lz_sync");
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_upd_ack !== 1'b1 && n < 80);
    chk("lz_ack", 32'(bus.o_upd_ack), 32'd1);
    bus.i_upd = 1'b0;
    wait_digit(0, 8'hC0, "lz_d0");
    wait_digit(1, 8'h92, "lz_d1");
    wait_digit(2, 8'hFF, "lz_d2");
    wait_digit(3, 8'hFF, "lz_d3");
    bus.i_dp = 4'b1000; bus.i_upd = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_upd_ack !== 1'b1 && n < 80);
    chk("lz_ack2", 32'(bus.o_upd_ack), 32'd1);
    bus.i_upd = 1'b0;
    wait_digit(2, 8'hC0, "lz_dp_d2");
    wait_digit(3, 8'h40, "lz_dp_d3");
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
